bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/sap_pkg.sv | 22 ++
 rtl/bus_arb_select.sv | 66 ++++++
 rtl/bus_arbiter.sv | 137 +++++++++++++
 tb/tb_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// sap_pkg: shared constants for the bus arbiter.
// Holds the FSM state encoding, default parameter values, the
// contention counter width/saturation value and the request-count codes.
package sap_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 8;
    localparam int unsigned DEFAULT_NUM_SOURCES = 5;

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_SAT = 8'd255;

    // FSM state encoding as seen on the state output
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] DRIVE   = 2'b01;
    localparam logic [1:0] CONTEND = 2'b10;

    // Active-request count, saturated at "two or more"
    localparam logic [1:0] REQS_NONE = 2'd0;
    localparam logic [1:0] REQS_ONE  = 2'd1;
    localparam logic [1:0] REQS_MANY = 2'd2;

endpackage

// File: rtl/bus_arb_select.sv
// bus_arb_select: combinational winner selection.
// Ports:
//   req      - active-high request vector, one bit per channel
//   ptr      - last granted index (only when BUS_ARBITER_RR_EN is defined)
//   grant_c  - one-hot winner, all zero when nothing requests
//   count_c  - active-request count: 0, 1 or 2 (= two or more)
// Macro BUS_ARBITER_RR_EN selects round-robin; otherwise lowest index wins.
module bus_arb_select
    import sap_pkg::*;
#(
    parameter int unsigned NUM_SOURCES = DEFAULT_NUM_SOURCES
) (
    input  logic [NUM_SOURCES-1:0] req,
`ifdef BUS_ARBITER_RR_EN
    input  logic [$clog2(NUM_SOURCES)-1:0] ptr,
`endif
    output logic [NUM_SOURCES-1:0] grant_c,
    output logic [1:0]             count_c
);

    // Request count, saturating at REQS_MANY
    always_comb begin
        count_c = REQS_NONE;
        for (int i = 0; i < int'(NUM_SOURCES); i++) begin
            if (req[i]) begin
                count_c = (count_c == REQS_NONE) ? REQS_ONE : REQS_MANY;
            end
        end
    end

`ifdef BUS_ARBITER_RR_EN
    localparam int unsigned PTR_W = $clog2(NUM_SOURCES);

    logic [31:0]      idx;
    logic [PTR_W-1:0] sel;
    logic             found;

    // Search starts one above the last grant and wraps to channel 0
    always_comb begin
        grant_c = '0;
        found   = 1'b0;
        idx     = '0;
        sel     = '0;
        for (int unsigned k = 1; k <= NUM_SOURCES; k++) begin
            idx = (32'(ptr) + 32'(k)) % 32'(NUM_SOURCES);
            sel = PTR_W'(idx);
            if (!found && req[sel]) begin
                grant_c[sel] = 1'b1;
                found        = 1'b1;
            end
        end
    end
`else
    // Fixed priority: scanning downward leaves the lowest active index
    always_comb begin
        grant_c = '0;
        for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_c    = '0;
                grant_c[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: registered multi-source bus arbiter with contention status.
// Ports:
//   clk, reset_n       - system clock, asynchronous active-low reset
//   src_data           - packed source words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_enable_n       - active-low drive requests, one per channel
//   clear_status       - synchronous clear of contention count/sticky flag
//   bus_out, bus_valid - registered bus word and its valid flag
//   grant              - registered one-hot owner of bus_out (or zero)
//   state              - 00 IDLE, 01 DRIVE, 10 CONTEND
//   contention         - one-cycle pulse, aligned with grant
//   contention_sticky  - latched contention flag
//   contention_count   - saturating count of contention cycles
// Macro BUS_ARBITER_RR_EN enables round-robin arbitration in CONTEND.
module bus_arbiter
    import sap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_SOURCES = DEFAULT_NUM_SOURCES
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SOURCES-1:0]            src_enable_n,
    input  logic                              clear_status,
    output logic [DATA_WIDTH-1:0]             bus_out,
    output logic                              bus_valid,
    output logic [NUM_SOURCES-1:0]            grant,
    output logic [1:0]                        state,
    output logic                              contention,
    output logic                              contention_sticky,
    output logic [CNT_W-1:0]                  contention_count
);

    logic [NUM_SOURCES-1:0] req_c;
    logic [NUM_SOURCES-1:0] sel_grant_c;
    logic [1:0]             req_count_c;

    logic [1:0]             state_d;
    logic [DATA_WIDTH-1:0]  bus_d;
    logic                   contend_c;
    logic                   sticky_d;
    logic [CNT_W-1:0]       count_d;

    assign req_c = ~src_enable_n;

`ifdef BUS_ARBITER_RR_EN
    localparam int unsigned PTR_W = $clog2(NUM_SOURCES);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Pointer follows every grant, in DRIVE as well as CONTEND
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < int'(NUM_SOURCES); i++) begin
            if (sel_grant_c[i]) begin
                ptr_d = PTR_W'(i);
            end
        end
    end

    // Reset to the top index so channel 0 wins the first contention
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= PTR_W'(NUM_SOURCES - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    bus_arb_select #(
        .NUM_SOURCES (NUM_SOURCES)
    ) u_select (
        .req     (req_c),
`ifdef BUS_ARBITER_RR_EN
        .ptr     (ptr_q),
`endif
        .grant_c (sel_grant_c),
        .count_c (req_count_c)
    );

    // Next state depends only on the request count, never on the current state
    always_comb begin
        state_d = IDLE;
        case (req_count_c)
            REQS_ONE:  state_d = DRIVE;
            REQS_MANY: state_d = CONTEND;
            default:   state_d = IDLE;
        endcase
    end

    // Next-cycle output values
    always_comb begin
        bus_d     = '0;
        contend_c = (state_d == CONTEND);
        sticky_d  = contention_sticky;
        count_d   = contention_count;

        for (int i = 0; i < int'(NUM_SOURCES); i++) begin
            if (sel_grant_c[i]) begin
                bus_d = bus_d | src_data[i*int'(DATA_WIDTH) +: DATA_WIDTH];
            end
        end

        // A contention in the clearing cycle survives the clear
        if (clear_status) begin
            sticky_d = contend_c;
            count_d  = contend_c ? CNT_W'(1) : '0;
        end else if (contend_c) begin
            sticky_d = 1'b1;
            count_d  = (contention_count == CNT_SAT) ? CNT_SAT
                                                     : contention_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            bus_out           <= '0;
            bus_valid         <= 1'b0;
            grant             <= '0;
            contention        <= 1'b0;
            contention_sticky <= 1'b0;
            contention_count  <= '0;
        end else begin
            state             <= state_d;
            bus_out           <= bus_d;
            bus_valid         <= (state_d != IDLE);
            grant             <= sel_grant_c;
            contention        <= contend_c;
            contention_sticky <= sticky_d;
            contention_count  <= count_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: self-checking bench for bus_arbiter (5 channels x 8 bits).
// Expected outputs are queued as stimulus is driven and compared one edge later.
// Define BUS_ARBITER_RR_EN for both RTL and bench to exercise round-robin.
module tb_bus_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned NS = 5;

    logic              clk;
    logic              reset_n;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_enable_n;
    logic              clear_status;
    logic [DW-1:0]     bus_out;
    logic              bus_valid;
    logic [NS-1:0]     grant;
    logic [1:0]        state;
    logic              contention;
    logic              contention_sticky;
    logic [7:0]        contention_count;

    bus_arbiter #(
        .DATA_WIDTH  (DW),
        .NUM_SOURCES (NS)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .src_data          (src_data),
        .src_enable_n      (src_enable_n),
        .clear_status      (clear_status),
        .bus_out           (bus_out),
        .bus_valid         (bus_valid),
        .grant             (grant),
        .state             (state),
        .contention        (contention),
        .contention_sticky (contention_sticky),
        .contention_count  (contention_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bus;
        logic       valid;
        logic [4:0] grant;
        logic [1:0] state;
        logic       cont;
        logic       sticky;
        logic [7:0] count;
        bit         chk_grant;
    } exp_t;

    typedef struct {
        logic [4:0]  en_n;
        logic [39:0] data;
        logic        clr;
        exp_t        exp;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk_exp(input logic [7:0] b, input logic v, input logic [4:0] g,
                                    input logic [1:0] s, input logic c, input logic st,
                                    input logic [7:0] n, input bit cg);
        exp_t e;
        e.bus = b; e.valid = v; e.grant = g; e.state = s;
        e.cont = c; e.sticky = st; e.count = n; e.chk_grant = cg;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [4:0] en_n, input logic [39:0] data,
                                    input logic clr, input exp_t e);
        vec_t v;
        v.en_n = en_n; v.data = data; v.clr = clr; v.exp = e;
        return v;
    endfunction

    // Channel 4 word first, channel 0 word last
    function automatic logic [39:0] pk(input logic [7:0] d4, input logic [7:0] d3,
                                       input logic [7:0] d2, input logic [7:0] d1,
                                       input logic [7:0] d0);
        return {d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".state"},   64'(state), 64'd0);
        check({tag, ".bus_out"}, 64'(bus_out), 64'd0);
        check({tag, ".valid"},   64'(bus_valid), 64'd0);
        check({tag, ".grant"},   64'(grant), 64'd0);
        check({tag, ".cont"},    64'(contention), 64'd0);
        check({tag, ".sticky"},  64'(contention_sticky), 64'd0);
        check({tag, ".count"},   64'(contention_count), 64'd0);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".state"},  64'(state), 64'(e.state));
            check({tag, ".valid"},  64'(bus_valid), 64'(e.valid));
            check({tag, ".cont"},   64'(contention), 64'(e.cont));
            check({tag, ".sticky"}, 64'(contention_sticky), 64'(e.sticky));
            check({tag, ".count"},  64'(contention_count), 64'(e.count));
            if (e.chk_grant) begin
                check({tag, ".grant"},   64'(grant), 64'(e.grant));
                check({tag, ".bus_out"}, 64'(bus_out), 64'(e.bus));
            end
        end
    endtask

    task automatic step(input logic [4:0] en_n, input logic [39:0] data, input logic clr,
                        input exp_t e, input string tag);
        @(negedge clk);
        src_enable_n = en_n;
        src_data     = data;
        clear_status = clr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n      = 1'b0;
        src_enable_n = '1;
        src_data     = '0;
        clear_status = 1'b0;
        @(negedge clk);
        check_zero(tag);
        reset_n = 1'b1;
    endtask

    vec_t       vecs[10];
    logic [4:0] rr_exp[4];
    logic [7:0] rr_bus[4];

    initial begin
        clk          = 1'b0;
        reset_n      = 1'b0;
        src_enable_n = '1;
        src_data     = '0;
        clear_status = 1'b0;

        vecs[0] = mk_vec(5'b11111, pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0,
                         mk_exp(8'h00, 1'b0, 5'b00000, 2'b00, 1'b0, 1'b0, 8'd0, 1'b1));
        vecs[1] = mk_vec(5'b11011, pk(8'h00, 8'h00, 8'h5A, 8'h00, 8'h00), 1'b0,
                         mk_exp(8'h5A, 1'b1, 5'b00100, 2'b01, 1'b0, 1'b0, 8'd0, 1'b1));
        vecs[2] = mk_vec(5'b11011, pk(8'hFF, 8'h00, 8'h7E, 8'h00, 8'h00), 1'b0,
                         mk_exp(8'h7E, 1'b1, 5'b00100, 2'b01, 1'b0, 1'b0, 8'd0, 1'b1));
        vecs[3] = mk_vec(5'b01111, pk(8'hC4, 8'h00, 8'h7E, 8'h00, 8'h00), 1'b0,
                         mk_exp(8'hC4, 1'b1, 5'b10000, 2'b01, 1'b0, 1'b0, 8'd0, 1'b1));
        vecs[4] = mk_vec(5'b11110, pk(8'hC4, 8'h00, 8'h00, 8'h00, 8'h01), 1'b0,
                         mk_exp(8'h01, 1'b1, 5'b00001, 2'b01, 1'b0, 1'b0, 8'd0, 1'b1));
        vecs[5] = mk_vec(5'b11111, pk(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A), 1'b0,
                         mk_exp(8'h00, 1'b0, 5'b00000, 2'b00, 1'b0, 1'b0, 8'd0, 1'b1));
        vecs[6] = mk_vec(5'b10101, pk(8'h00, 8'h33, 8'h00, 8'h11, 8'h00), 1'b0,
                         mk_exp(8'h11, 1'b1, 5'b00010, 2'b10, 1'b1, 1'b1, 8'd1, 1'b1));
        vecs[7] = mk_vec(5'b11111, pk(8'h00, 8'h33, 8'h00, 8'h11, 8'h00), 1'b0,
                         mk_exp(8'h00, 1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 8'd1, 1'b1));
        vecs[8] = mk_vec(5'b11111, pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1,
                         mk_exp(8'h00, 1'b0, 5'b00000, 2'b00, 1'b0, 1'b0, 8'd0, 1'b1));
        vecs[9] = mk_vec(5'b10111, pk(8'h00, 8'h33, 8'h00, 8'h00, 8'h00), 1'b0,
                         mk_exp(8'h33, 1'b1, 5'b01000, 2'b01, 1'b0, 1'b0, 8'd0, 1'b1));

        // Reset held with the clock running
        #22;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].en_n, vecs[i].data, vecs[i].clr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Channels 0, 1 and 3 held for four cycles straight after reset
        do_reset("rst_a");
`ifdef BUS_ARBITER_RR_EN
        rr_exp[0] = 5'b00001; rr_exp[1] = 5'b00010; rr_exp[2] = 5'b01000; rr_exp[3] = 5'b00001;
        rr_bus[0] = 8'hA0;    rr_bus[1] = 8'h11;    rr_bus[2] = 8'h33;    rr_bus[3] = 8'hA0;
`else
        for (int i = 0; i < 4; i++) begin
            rr_exp[i] = 5'b00001;
            rr_bus[i] = 8'hA0;
        end
`endif
        for (int i = 0; i < 4; i++) begin
            step(5'b10100, pk(8'h00, 8'h33, 8'h00, 8'h11, 8'hA0), 1'b0,
                 mk_exp(rr_bus[i], 1'b1, rr_exp[i], 2'b10, 1'b1, 1'b1, 8'(i + 1), 1'b1),
                 $sformatf("multi%0d", i));
        end

        // Saturation of the contention counter
        do_reset("rst_b");
        for (int i = 1; i <= 300; i++) begin
            step(5'b11100, pk(8'h00, 8'h00, 8'h00, 8'hB1, 8'hB0), 1'b0,
                 mk_exp(8'h00, 1'b1, 5'b00000, 2'b10, 1'b1, 1'b1, 8'((i > 255) ? 255 : i), 1'b0),
                 $sformatf("sat%0d", i));
        end
        step(5'b11100, pk(8'h00, 8'h00, 8'h00, 8'hB1, 8'hB0), 1'b1,
             mk_exp(8'h00, 1'b1, 5'b00000, 2'b10, 1'b1, 1'b1, 8'd1, 1'b0), "clr_cont");
        step(5'b11111, pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1,
             mk_exp(8'h00, 1'b0, 5'b00000, 2'b00, 1'b0, 1'b0, 8'd0, 1'b1), "clr_idle");

        // Asynchronous reset while channel 4 owns the bus
        step(5'b01111, pk(8'hC4, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0,
             mk_exp(8'hC4, 1'b1, 5'b10000, 2'b01, 1'b0, 1'b0, 8'd0, 1'b1), "own4");
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("midrst");
        src_enable_n = 5'b11011;
        src_data     = pk(8'hC4, 8'h00, 8'h5A, 8'h00, 8'h00);
        @(negedge clk);
        check_zero("midrst_hold");
        reset_n = 1'b1;
        sb.push_back(mk_exp(8'h5A, 1'b1, 5'b00100, 2'b01, 1'b0, 1'b0, 8'd0, 1'b1));
        @(posedge clk);
        #1;
        compare("first_edge");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
